// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared forwarding selects, HI/LO tracker states and register constants
package pipe_ctrl_pkg;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;
  localparam logic [4:0] REG_ZERO = 5'd0;
  typedef enum logic {HL_IDLE = 1'b0, HL_BUSY = 1'b1} hlState_t;
endpackage

// File: rtl/muldiv_busy_tracker.sv
// muldiv_busy_tracker: HI/LO occupancy FSM with down-counter
//   Clk, Rst (async active-low), Issue (mult/div accepted into EX), Busy (registered occupancy)
module muldiv_busy_tracker
  import pipe_ctrl_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W = 6
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Issue,
  output logic Busy
);
  hlState_t state;
  logic [CNT_W-1:0] cnt;
  // Loading MULDIV_CYCLES-1 and leaving on zero gives exactly MULDIV_CYCLES busy cycles
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= HL_IDLE;
      cnt <= '0;
    end else if (state == HL_IDLE) begin
      if (Issue) begin
        state <= HL_BUSY;
        cnt <= CNT_W'(MULDIV_CYCLES - 1);
      end
    end else begin
      cnt <= (cnt == '0) ? cnt : cnt - 1'b1;
      if (cnt == '0) state <= HL_IDLE;
    end
  end
  assign Busy = (state == HL_BUSY);
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: 5-stage MIPS hazard, stall/flush and EX forwarding control
//   in : Clk, Rst (async active-low), DEC sources/uses, HI/LO reads, mult/div, EX/MEM/WB writeback info, PCRedirect_EX
//   out: PCWrite, IFDECWrite, IFDECFlush, DECEXBubble, ForwardA/B (00 RF, 01 MEM, 10 WB), MulDivBusy
module hazard_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULDIV_CYCLES = 32,
  parameter int CNT_W = 6
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [4:0] Rs_DEC,
  input  logic [4:0] Rt_DEC,
  input  logic       UsesRs_DEC,
  input  logic       UsesRt_DEC,
  input  logic       ReadsHiLo_DEC,
  input  logic       MulDiv_DEC,
  input  logic [4:0] Rs_EX,
  input  logic [4:0] Rt_EX,
  input  logic       MemRead_EX,
  input  logic       RegWrite_EX,
  input  logic [4:0] WriteReg_EX,
  input  logic       RegWrite_MEM,
  input  logic [4:0] WriteReg_MEM,
  input  logic       RegWrite_WB,
  input  logic [4:0] WriteReg_WB,
  input  logic       PCRedirect_EX,
  output logic       PCWrite,
  output logic       IFDECWrite,
  output logic       IFDECFlush,
  output logic       DECEXBubble,
  output logic [1:0] ForwardA,
  output logic [1:0] ForwardB,
  output logic       MulDivBusy
);
  logic memA, memB, wbA, wbB, loadUse, hiloStall, stall, issue;
  // A load always writes its destination, so load-use keys on MemRead_EX alone
  logic unusedRegWriteEx;
  assign unusedRegWriteEx = RegWrite_EX;
  always_comb begin
    memA = RegWrite_MEM && WriteReg_MEM != REG_ZERO && WriteReg_MEM == Rs_EX;
    memB = RegWrite_MEM && WriteReg_MEM != REG_ZERO && WriteReg_MEM == Rt_EX;
    wbA = RegWrite_WB && WriteReg_WB != REG_ZERO && WriteReg_WB == Rs_EX;
    wbB = RegWrite_WB && WriteReg_WB != REG_ZERO && WriteReg_WB == Rt_EX;
    loadUse = MemRead_EX && WriteReg_EX != REG_ZERO &&
              ((UsesRs_DEC && Rs_DEC == WriteReg_EX) || (UsesRt_DEC && Rt_DEC == WriteReg_EX));
    hiloStall = (ReadsHiLo_DEC || MulDiv_DEC) && MulDivBusy;
    stall = loadUse || hiloStall;
    // A squashed or stalled DEC mult/div must not start the unit
    issue = MulDiv_DEC && !stall && !PCRedirect_EX;
    PCWrite = Rst && (PCRedirect_EX || !stall);
    IFDECWrite = Rst && (PCRedirect_EX || !stall);
    IFDECFlush = !Rst || PCRedirect_EX;
    DECEXBubble = !Rst || PCRedirect_EX || stall;
    ForwardA = !Rst ? FWD_RF : memA ? FWD_MEM : wbA ? FWD_WB : FWD_RF;
    ForwardB = !Rst ? FWD_RF : memB ? FWD_MEM : wbB ? FWD_WB : FWD_RF;
  end
  muldiv_busy_tracker #(.MULDIV_CYCLES(MULDIV_CYCLES), .CNT_W(CNT_W)) uTracker (
    .Clk(Clk),
    .Rst(Rst),
    .Issue(issue),
    .Busy(MulDivBusy)
  );
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;
  logic Clk = 1'b0, Rst = 1'b0;
  logic [4:0] Rs_DEC, Rt_DEC, Rs_EX, Rt_EX, WriteReg_EX, WriteReg_MEM, WriteReg_WB;
  logic UsesRs_DEC, UsesRt_DEC, ReadsHiLo_DEC, MulDiv_DEC, MemRead_EX, RegWrite_EX;
  logic RegWrite_MEM, RegWrite_WB, PCRedirect_EX;
  logic PCWrite, IFDECWrite, IFDECFlush, DECEXBubble, MulDivBusy;
  logic [1:0] ForwardA, ForwardB;
  int checks = 0, fails = 0;
  int busyCycles;
  logic stalledOk;

  hazard_stall_ctrl #(.MULDIV_CYCLES(32), .CNT_W(6)) dut (
    .Clk(Clk), .Rst(Rst),
    .Rs_DEC(Rs_DEC), .Rt_DEC(Rt_DEC), .UsesRs_DEC(UsesRs_DEC), .UsesRt_DEC(UsesRt_DEC),
    .ReadsHiLo_DEC(ReadsHiLo_DEC), .MulDiv_DEC(MulDiv_DEC),
    .Rs_EX(Rs_EX), .Rt_EX(Rt_EX), .MemRead_EX(MemRead_EX), .RegWrite_EX(RegWrite_EX),
    .WriteReg_EX(WriteReg_EX), .RegWrite_MEM(RegWrite_MEM), .WriteReg_MEM(WriteReg_MEM),
    .RegWrite_WB(RegWrite_WB), .WriteReg_WB(WriteReg_WB), .PCRedirect_EX(PCRedirect_EX),
    .PCWrite(PCWrite), .IFDECWrite(IFDECWrite), .IFDECFlush(IFDECFlush),
    .DECEXBubble(DECEXBubble), .ForwardA(ForwardA), .ForwardB(ForwardB),
    .MulDivBusy(MulDivBusy)
  );

  always #5 Clk = ~Clk;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clearIn;
    {Rs_DEC, Rt_DEC, Rs_EX, Rt_EX, WriteReg_EX, WriteReg_MEM, WriteReg_WB} = '0;
    {UsesRs_DEC, UsesRt_DEC, ReadsHiLo_DEC, MulDiv_DEC, MemRead_EX, RegWrite_EX} = '0;
    {RegWrite_MEM, RegWrite_WB, PCRedirect_EX} = '0;
  endtask

  task automatic nextCycle;
    @(posedge Clk);
    #2;
  endtask

  initial begin
    clearIn;
    RegWrite_MEM = 1; WriteReg_MEM = 5'd8; Rs_EX = 5'd8;
    #3;
    checkEq("rst pcwrite", PCWrite, 0);
    checkEq("rst ifdecwrite", IFDECWrite, 0);
    checkEq("rst flush", IFDECFlush, 1);
    checkEq("rst bubble", DECEXBubble, 1);
    checkEq("rst fwdA", ForwardA, 0);
    checkEq("rst busy", MulDivBusy, 0);
    #4 Rst = 1;
    nextCycle; clearIn; #1;
    checkEq("idle pcwrite", PCWrite, 1);
    checkEq("idle ifdecwrite", IFDECWrite, 1);
    checkEq("idle flush", IFDECFlush, 0);
    checkEq("idle bubble", DECEXBubble, 0);
    // lw $t0 in EX, add $t1,$t0,$t2 in DEC
    nextCycle; clearIn;
    MemRead_EX = 1; RegWrite_EX = 1; WriteReg_EX = 5'd8;
    Rs_DEC = 5'd8; UsesRs_DEC = 1; Rt_DEC = 5'd10; UsesRt_DEC = 1; #1;
    checkEq("lu pcwrite", PCWrite, 0);
    checkEq("lu ifdecwrite", IFDECWrite, 0);
    checkEq("lu bubble", DECEXBubble, 1);
    checkEq("lu flush", IFDECFlush, 0);
    nextCycle; clearIn;
    RegWrite_MEM = 1; WriteReg_MEM = 5'd8; Rs_DEC = 5'd8; UsesRs_DEC = 1; #1;
    checkEq("lu released pcwrite", PCWrite, 1);
    checkEq("lu released bubble", DECEXBubble, 0);
    nextCycle; clearIn;
    RegWrite_WB = 1; WriteReg_WB = 5'd8; Rs_EX = 5'd8; Rt_EX = 5'd10; #1;
    checkEq("lu fwdA wb", ForwardA, 2);
    checkEq("lu fwdB rf", ForwardB, 0);
    // rt-only load-use, unused operand, and $zero destination
    clearIn; MemRead_EX = 1; WriteReg_EX = 5'd9; Rt_DEC = 5'd9; UsesRt_DEC = 1; Rs_DEC = 5'd9; #1;
    checkEq("lu rt pcwrite", PCWrite, 0);
    UsesRt_DEC = 0; #1;
    checkEq("lu unused pcwrite", PCWrite, 1);
    WriteReg_EX = 5'd0; Rt_DEC = 5'd0; Rs_DEC = 5'd0; UsesRt_DEC = 1; UsesRs_DEC = 1; #1;
    checkEq("lu zero pcwrite", PCWrite, 1);
    // forwarding priority
    clearIn; RegWrite_MEM = 1; WriteReg_MEM = 5'd8; RegWrite_WB = 1; WriteReg_WB = 5'd8;
    Rs_EX = 5'd8; Rt_EX = 5'd8; #1;
    checkEq("fwdA mem prio", ForwardA, 1);
    checkEq("fwdB mem prio", ForwardB, 1);
    RegWrite_MEM = 0; #1;
    checkEq("fwdA wb only", ForwardA, 2);
    RegWrite_MEM = 1; WriteReg_MEM = 5'd0; WriteReg_WB = 5'd0; Rs_EX = 5'd0; #1;
    checkEq("fwdA zero", ForwardA, 0);
    WriteReg_WB = 5'd3; Rt_EX = 5'd3; #1;
    checkEq("fwdB wb", ForwardB, 2);
    // mult issued, mfhi waits in DEC
    nextCycle; clearIn; MulDiv_DEC = 1; #1;
    checkEq("mult issue pcwrite", PCWrite, 1);
    checkEq("mult issue busy", MulDivBusy, 0);
    nextCycle; clearIn; ReadsHiLo_DEC = 1; #1;
    busyCycles = 0; stalledOk = 1;
    while (MulDivBusy === 1'b1 && busyCycles < 100) begin
      busyCycles++;
      if (busyCycles == 5) begin
        PCRedirect_EX = 1; #1;
        checkEq("busy redirect pcwrite", PCWrite, 1);
        checkEq("busy redirect flush", IFDECFlush, 1);
      end else if (PCWrite !== 1'b0 || DECEXBubble !== 1'b1) stalledOk = 0;
      nextCycle; PCRedirect_EX = 0; ReadsHiLo_DEC = 1; #1;
    end
    checkEq("busy cycles", busyCycles, 32);
    checkEq("hilo stall held", {31'd0, stalledOk}, 1);
    checkEq("mfhi issue pcwrite", PCWrite, 1);
    checkEq("mfhi issue bubble", DECEXBubble, 0);
    // load-use plus redirect, with a squashed mult in DEC
    nextCycle; clearIn;
    MemRead_EX = 1; WriteReg_EX = 5'd8; Rs_DEC = 5'd8; UsesRs_DEC = 1;
    MulDiv_DEC = 1; PCRedirect_EX = 1; #1;
    checkEq("redir pcwrite", PCWrite, 1);
    checkEq("redir ifdecwrite", IFDECWrite, 1);
    checkEq("redir flush", IFDECFlush, 1);
    checkEq("redir bubble", DECEXBubble, 1);
    nextCycle; clearIn; #1;
    checkEq("post redir busy", MulDivBusy, 0);
    checkEq("post redir pcwrite", PCWrite, 1);
    checkEq("post redir bubble", DECEXBubble, 0);
    // async reset in the middle of a mult
    nextCycle; clearIn; MulDiv_DEC = 1;
    nextCycle; clearIn;
    repeat (21) nextCycle;
    #1;
    checkEq("mid busy", MulDivBusy, 1);
    MulDiv_DEC = 1; #1;
    checkEq("muldiv stall pcwrite", PCWrite, 0);
    MulDiv_DEC = 0; #1;
    Rst = 0; #1;
    checkEq("async rst busy", MulDivBusy, 0);
    checkEq("async rst pcwrite", PCWrite, 0);
    #1 Rst = 1;
    ReadsHiLo_DEC = 1; #1;
    checkEq("mflo after rst pcwrite", PCWrite, 1);
    checkEq("mflo after rst bubble", DECEXBubble, 0);
    nextCycle; #1;
    checkEq("after rst busy", MulDivBusy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
